ren_conv_seq_ctrl: RTL and testbench

//  Loop sequencer for the ren_conv datapath: walks kernel x column x kernel-column loops from latched config.

---
 rtl/ren_conv_pkg.sv | 29 ++
 rtl/ren_conv_tag_pipe.sv | 56 +++++
 rtl/ren_conv_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ren_conv_seq_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ren_conv_pkg.sv
// ren_conv shared types: sequencer FSM states, tag-pipe bundle,
// kernel slot base size and the stride-zero substitution rule.
package ren_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Kernel slot size in words for kern_addr_mode = 0; mode 1 doubles it.
    localparam int unsigned KERN_SLOT_WORDS = 4;

    // A programmed stride of zero walks the image as if it were one.
    localparam logic [7:0] STRIDE_ZERO_AS = 8'd1;

    typedef struct packed {
        logic clr;
        logic last;
        logic col_odd;
        logic col_final;
    } tag_t;

    function automatic logic [7:0] eff_stride(input logic [7:0] s);
        return (s == 8'd0) ? STRIDE_ZERO_AS : s;
    endfunction

endpackage

// File: rtl/ren_conv_tag_pipe.sv
// ren_conv_tag_pipe: enable-gated shift register that delays the
// read tags by PIPE_LAT datapath advances.
// Ports: clk, reset_n (sync, active-low), flush_i (sync clear),
//   en_i (advance), tag_i (tag entering), last_o/col_odd_o/col_final_o
//   (tag leaving), busy_o (any live entry still in flight).
module ren_conv_tag_pipe
    import ren_conv_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush_i,
    input  logic en_i,
    input  tag_t tag_i,
    output logic last_o,
    output logic col_odd_o,
    output logic col_final_o,
    output logic busy_o
);

    tag_t [PIPE_LAT-1:0] stage_q;
    tag_t [PIPE_LAT-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = tag_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Every issued read carries clr or last at a column boundary, and the
    // final read of a run always carries last, so this is an empty test.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            busy_o = busy_o | stage_q[i].clr | stage_q[i].last;
        end
    end

    assign last_o      = stage_q[PIPE_LAT-1].last;
    assign col_odd_o   = stage_q[PIPE_LAT-1].col_odd;
    assign col_final_o = stage_q[PIPE_LAT-1].col_final;

endmodule

// File: rtl/ren_conv_seq_ctrl.sv
// ren_conv_seq_ctrl: loop sequencer for the ren_conv datapath. Walks
// kernel x column x kernel-column loops, issues image/kernel reads with
// accumulate tags, then pool-capture and result-write strobes.
// Ports: clk, reset_n (sync active-low), soft_rst_i, start_i (rising
//   edge starts), config inputs (kern_cols/cols/kerns/stride/mode/
//   result_cols/en_max_pool), dp_ready_i (advance enable);
//   img_addr_o, kern_addr_o, rd_en_o, acc_clr_o, acc_last_o,
//   pool_cap_o, rslt_we_o, rslt_addr_o, busy_o, done_o, err_o.
// Optional: define REN_CONV_PERF_CNT_EN for perf_cycles_o/perf_stalls_o.
module ren_conv_seq_ctrl
    import ren_conv_pkg::*;
#(
    parameter int KERN_COL_WIDTH  = 3,
    parameter int COL_WIDTH       = 8,
    parameter int KERN_CNT_WIDTH  = 3,
    parameter int IMG_ADDR_WIDTH  = 6,
    parameter int KERN_ADDR_WIDTH = 6,
    parameter int RSLT_ADDR_WIDTH = 6,
    parameter int PIPE_LAT        = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       soft_rst_i,
    input  logic                       start_i,
    input  logic [KERN_COL_WIDTH-1:0]  kern_cols_i,
    input  logic [COL_WIDTH-1:0]       cols_i,
    input  logic [KERN_CNT_WIDTH-1:0]  kerns_i,
    input  logic [7:0]                 stride_i,
    input  logic                       kern_addr_mode_i,
    input  logic [7:0]                 result_cols_i,
    input  logic                       en_max_pool_i,
    input  logic                       dp_ready_i,
    output logic [IMG_ADDR_WIDTH-1:0]  img_addr_o,
    output logic [KERN_ADDR_WIDTH-1:0] kern_addr_o,
    output logic                       rd_en_o,
    output logic                       acc_clr_o,
    output logic                       acc_last_o,
    output logic                       pool_cap_o,
    output logic                       rslt_we_o,
    output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_o,
    output logic                       busy_o,
    output logic                       done_o,
`ifdef REN_CONV_PERF_CNT_EN
    output logic [31:0]                perf_cycles_o,
    output logic [31:0]                perf_stalls_o,
`endif
    output logic                       err_o
);

    // Untruncated c*stride + kc needs the column and stride widths plus a carry.
    localparam int IMG_FULL_W = COL_WIDTH + 9;

    state_e state_q, state_d;
    logic   start_prev_q, start_prev_d;

    logic [KERN_COL_WIDTH-1:0] kcols_q, kcols_d, kc_q, kc_d;
    logic [COL_WIDTH-1:0]      cols_q, cols_d, c_q, c_d;
    logic [KERN_CNT_WIDTH-1:0] kerns_q, kerns_d, ks_q, ks_d;
    logic [7:0]                stride_q, stride_d;
    logic [7:0]                rcols_q, rcols_d;
    logic                      mode_q, mode_d;
    logic                      pool_q, pool_d;

    logic [IMG_FULL_W-1:0]      img_base_q, img_base_d;
    logic [KERN_ADDR_WIDTH-1:0] kern_base_q, kern_base_d;
    logic [8:0]                 wr_cnt_q, wr_cnt_d;
    logic [RSLT_ADDR_WIDTH-1:0] rslt_addr_q, rslt_addr_d;
    logic                       err_q, err_d;

    logic rst_now, active, run, start_edge;
    logic kc_last, c_last, ks_last;
    logic [IMG_FULL_W-1:0]      img_full;
    logic                       img_ovf;
    logic [KERN_ADDR_WIDTH-1:0] slot_words;
    tag_t tag_in;
    logic p_last, p_odd, p_final, pipe_busy;
    logic col_evt, pair_wr, wr_ok;

    assign rst_now    = !reset_n || soft_rst_i;
    assign active     = (state_q == ST_RUN || state_q == ST_DRAIN) && !rst_now;
    assign run        = (state_q == ST_RUN) && !rst_now;
    assign start_edge = start_i && !start_prev_q;

    assign kc_last = (kc_q == kcols_q);
    assign c_last  = (c_q == cols_q);
    assign ks_last = (ks_q == kerns_q);

    assign img_full   = img_base_q + IMG_FULL_W'(kc_q);
    assign img_ovf    = |img_full[IMG_FULL_W-1:IMG_ADDR_WIDTH];
    assign slot_words = KERN_ADDR_WIDTH'(KERN_SLOT_WORDS << mode_q);

    assign img_addr_o  = img_full[IMG_ADDR_WIDTH-1:0];
    assign kern_addr_o = kern_base_q + KERN_ADDR_WIDTH'(kc_q);
    assign rd_en_o     = run && dp_ready_i;
    assign acc_clr_o   = run && (kc_q == '0);
    assign acc_last_o  = run && kc_last;

    always_comb begin
        tag_in = '0;
        if (rd_en_o) begin
            tag_in.clr       = (kc_q == '0);
            tag_in.last      = kc_last;
            tag_in.col_odd   = c_q[0];
            tag_in.col_final = c_last;
        end
    end

    ren_conv_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (soft_rst_i),
        .en_i        (dp_ready_i),
        .tag_i       (tag_in),
        .last_o      (p_last),
        .col_odd_o   (p_odd),
        .col_final_o (p_final),
        .busy_o      (pipe_busy)
    );

    // A column completes when its last tag leaves the pipe on an advance.
    // With pooling, even columns are held for pairing unless they are the
    // kernel's final column, which has no partner.
    assign col_evt    = active && dp_ready_i && p_last;
    assign pair_wr    = !pool_q || p_odd || p_final;
    assign wr_ok      = (wr_cnt_q <= {1'b0, rcols_q});
    assign pool_cap_o = col_evt && !pair_wr;
    assign rslt_we_o  = col_evt && pair_wr && wr_ok;

    assign rslt_addr_o = rslt_addr_q;
    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;

    always_comb begin
        state_d      = state_q;
        start_prev_d = start_i;
        kcols_d      = kcols_q;
        cols_d       = cols_q;
        kerns_d      = kerns_q;
        stride_d     = stride_q;
        rcols_d      = rcols_q;
        mode_d       = mode_q;
        pool_d       = pool_q;
        kc_d         = kc_q;
        c_d          = c_q;
        ks_d         = ks_q;
        img_base_d   = img_base_q;
        kern_base_d  = kern_base_q;
        wr_cnt_d     = wr_cnt_q;
        rslt_addr_d  = rslt_addr_q;
        err_d        = err_q;

        if (rslt_we_o) begin
            wr_cnt_d    = wr_cnt_q + 9'd1;
            rslt_addr_d = rslt_addr_q + RSLT_ADDR_WIDTH'(1);
        end
        if (rd_en_o && img_ovf) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_RUN;
                    kcols_d     = kern_cols_i;
                    cols_d      = cols_i;
                    kerns_d     = kerns_i;
                    stride_d    = eff_stride(stride_i);
                    rcols_d     = result_cols_i;
                    mode_d      = kern_addr_mode_i;
                    pool_d      = en_max_pool_i;
                    kc_d        = '0;
                    c_d         = '0;
                    ks_d        = '0;
                    img_base_d  = '0;
                    kern_base_d = '0;
                    wr_cnt_d    = '0;
                    rslt_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (rd_en_o) begin
                    if (kc_last) begin
                        kc_d = '0;
                        if (c_last) begin
                            c_d        = '0;
                            img_base_d = '0;
                            if (ks_last) begin
                                state_d = ST_DRAIN;
                            end else begin
                                ks_d        = ks_q + KERN_CNT_WIDTH'(1);
                                kern_base_d = kern_base_q + slot_words;
                            end
                        end else begin
                            c_d        = c_q + COL_WIDTH'(1);
                            img_base_d = img_base_q + IMG_FULL_W'(stride_q);
                        end
                    end else begin
                        kc_d = kc_q + KERN_COL_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_now) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            kcols_q      <= '0;
            cols_q       <= '0;
            kerns_q      <= '0;
            stride_q     <= '0;
            rcols_q      <= '0;
            mode_q       <= 1'b0;
            pool_q       <= 1'b0;
            kc_q         <= '0;
            c_q          <= '0;
            ks_q         <= '0;
            img_base_q   <= '0;
            kern_base_q  <= '0;
            wr_cnt_q     <= '0;
            rslt_addr_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            kcols_q      <= kcols_d;
            cols_q       <= cols_d;
            kerns_q      <= kerns_d;
            stride_q     <= stride_d;
            rcols_q      <= rcols_d;
            mode_q       <= mode_d;
            pool_q       <= pool_d;
            kc_q         <= kc_d;
            c_q          <= c_d;
            ks_q         <= ks_d;
            img_base_q   <= img_base_d;
            kern_base_q  <= kern_base_d;
            wr_cnt_q     <= wr_cnt_d;
            rslt_addr_q  <= rslt_addr_d;
            err_q        <= err_d;
        end
    end

`ifdef REN_CONV_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == ST_IDLE && start_edge) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else if (active) begin
            if (perf_cycles_q != '1) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (!dp_ready_i && perf_stalls_q != '1) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_now) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_ren_conv_seq_ctrl.sv
// Bench for ren_conv_seq_ctrl: directed and random runs checked against
// a loop-level reference of the read, write and pool-capture streams.
module tb_ren_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       soft_rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [2:0] kern_cols_i = '0;
    logic [7:0] cols_i = '0;
    logic [2:0] kerns_i = '0;
    logic [7:0] stride_i = '0;
    logic       kern_addr_mode_i = 1'b0;
    logic [7:0] result_cols_i = '0;
    logic       en_max_pool_i = 1'b0;
    logic       dp_ready_i = 1'b1;

    logic [5:0] img_addr_o, kern_addr_o, rslt_addr_o;
    logic rd_en_o, acc_clr_o, acc_last_o, pool_cap_o, rslt_we_o;
    logic busy_o, done_o, err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] exp_rd[$], obs_rd[$];
    logic [5:0]  exp_wr[$], obs_wr[$];
    int exp_cap, obs_cap, obs_busy;
    bit exp_err;

    ren_conv_seq_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .soft_rst_i       (soft_rst_i),
        .start_i          (start_i),
        .kern_cols_i      (kern_cols_i),
        .cols_i           (cols_i),
        .kerns_i          (kerns_i),
        .stride_i         (stride_i),
        .kern_addr_mode_i (kern_addr_mode_i),
        .result_cols_i    (result_cols_i),
        .en_max_pool_i    (en_max_pool_i),
        .dp_ready_i       (dp_ready_i),
        .img_addr_o       (img_addr_o),
        .kern_addr_o      (kern_addr_o),
        .rd_en_o          (rd_en_o),
        .acc_clr_o        (acc_clr_o),
        .acc_last_o       (acc_last_o),
        .pool_cap_o       (pool_cap_o),
        .rslt_we_o        (rslt_we_o),
        .rslt_addr_o      (rslt_addr_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_en_o)
            obs_rd.push_back({acc_clr_o, acc_last_o, img_addr_o, kern_addr_o});
        if (rslt_we_o) obs_wr.push_back(rslt_addr_o);
        if (pool_cap_o) obs_cap++;
        if (busy_o) obs_busy++;
    end

    // Reference: the loop nest and column pairing rules in plain arithmetic.
    task automatic build_model(input int kc, cl, kn, st, md, rc, pl,
                               input bit err_in);
        int s, img, kern, nw;
        logic [13:0] e;
        exp_rd.delete();
        exp_wr.delete();
        exp_cap = 0;
        exp_err = err_in;
        s = (st == 0) ? 1 : st;
        nw = 0;
        for (int ks = 0; ks <= kn; ks++) begin
            for (int c = 0; c <= cl; c++) begin
                for (int k = 0; k <= kc; k++) begin
                    img = c * s + k;
                    kern = ks * (md ? 8 : 4) + k;
                    if (img >= 64) exp_err = 1'b1;
                    e = {k == 0, k == kc, 6'(img), 6'(kern)};
                    exp_rd.push_back(e);
                end
                if (pl == 0 || (c % 2) == 1 || c == cl) begin
                    if (nw < rc + 1) begin
                        exp_wr.push_back(6'(nw));
                        nw++;
                    end
                end else begin
                    exp_cap++;
                end
            end
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        reset_n = 1'b0;
        start_i = 1'b0;
        soft_rst_i = 1'b0;
        dp_ready_i = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic run_cfg(input string nm, input bit rst,
                           input int kc, cl, kn, st, md, rc, pl,
                           input int stall, input bit err_in,
                           output int busy_cyc);
        int n, bad;
        bit got;
        logic [5:0] h_img, h_kern;
        if (rst) do_reset();
        build_model(kc, cl, kn, st, md, rc, pl, rst ? 1'b0 : err_in);
        @(posedge clk); #1;
        kern_cols_i = 3'(kc);
        cols_i = 8'(cl);
        kerns_i = 3'(kn);
        stride_i = 8'(st);
        kern_addr_mode_i = md[0];
        result_cols_i = 8'(rc);
        en_max_pool_i = pl[0];
        dp_ready_i = 1'b1;
        obs_rd.delete();
        obs_wr.delete();
        obs_cap = 0;
        obs_busy = 0;
        start_i = 1'b1;
        got = 0;
        h_img = '0;
        h_kern = '0;
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            if (done_o) begin
                got = 1;
                break;
            end
            if (stall == 1) dp_ready_i = !(n >= 10 && n < 15);
            else if (stall == 2) dp_ready_i = ($urandom_range(0, 3) != 0);
            else dp_ready_i = 1'b1;
            #1;
            if (stall == 1 && n == 10) begin
                h_img = img_addr_o;
                h_kern = kern_addr_o;
            end
            if (stall == 1 && n > 10 && n < 15) begin
                n_cmp++;
                if (img_addr_o !== h_img || kern_addr_o !== h_kern
                    || rd_en_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s hold@%0d: got img=%0d kern=%0d rd=%b, want img=%0d kern=%0d rd=0",
                             nm, n, img_addr_o, kern_addr_o, rd_en_o, h_img, h_kern);
                end
            end
            n++;
        end
        dp_ready_i = 1'b1;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s done_timeout: got done=%b after %0d cycles, want done=1", nm, done_o, n);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_hold: got done=%b busy=%b, want done=1 busy=0", nm, done_o, busy_o);
        end
        start_i = 1'b0;
        @(posedge clk); #2;
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s to_idle: got done=%b busy=%b, want done=0 busy=0", nm, done_o, busy_o);
        end
        busy_cyc = obs_busy;

        bad = -1;
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) begin
            if (obs_rd[i] !== exp_rd[i]) begin
                bad = i;
                break;
            end
        end
        n_cmp++;
        if (obs_rd.size() != exp_rd.size() || bad >= 0) begin
            n_bad++;
            if (bad >= 0)
                $display("FAIL %s rd_seq: got read[%0d]=%h, want %h (got %0d reads, want %0d)",
                         nm, bad, obs_rd[bad], exp_rd[bad], obs_rd.size(), exp_rd.size());
            else
                $display("FAIL %s rd_seq: got %0d reads, want %0d", nm, obs_rd.size(), exp_rd.size());
        end

        bad = -1;
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
            if (obs_wr[i] !== exp_wr[i]) begin
                bad = i;
                break;
            end
        end
        n_cmp++;
        if (obs_wr.size() != exp_wr.size() || bad >= 0) begin
            n_bad++;
            if (bad >= 0)
                $display("FAIL %s wr_seq: got addr[%0d]=%0d, want %0d (got %0d writes, want %0d)",
                         nm, bad, obs_wr[bad], exp_wr[bad], obs_wr.size(), exp_wr.size());
            else
                $display("FAIL %s wr_seq: got %0d writes, want %0d", nm, obs_wr.size(), exp_wr.size());
        end

        n_cmp++;
        if (obs_cap != exp_cap) begin
            n_bad++;
            $display("FAIL %s caps: got %0d, want %0d", nm, obs_cap, exp_cap);
        end
        n_cmp++;
        if (err_o !== exp_err) begin
            n_bad++;
            $display("FAIL %s err: got %b, want %b", nm, err_o, exp_err);
        end
    endtask

    int busy_t1;

    task automatic test_reset;
        @(posedge clk); #1;
        reset_n = 1'b0;
        start_i = 1'b1;
        dp_ready_i = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if ({img_addr_o, kern_addr_o, rd_en_o, acc_clr_o, acc_last_o, pool_cap_o,
             rslt_we_o, rslt_addr_o, busy_o, done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got img=%0d kern=%0d rd=%b busy=%b done=%b err=%b, want all 0",
                     img_addr_o, kern_addr_o, rd_en_o, busy_o, done_o, err_o);
        end
        start_i = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (busy_o !== 1'b0 || rd_en_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b rd=%b, want 0 0", busy_o, rd_en_o);
        end
    endtask

    task automatic test_pool;
        run_cfg("t1_pool", 1, 1, 7, 2, 1, 0, 63, 1, 0, 0, busy_t1);
    endtask

    task automatic test_nopool_mode1;
        int b;
        run_cfg("t2_nopool", 1, 1, 7, 2, 1, 1, 63, 0, 0, 0, b);
    endtask

    task automatic test_stall;
        int b;
        run_cfg("t3_stall", 1, 1, 7, 2, 1, 0, 63, 1, 1, 0, b);
        n_cmp++;
        if (b != busy_t1 + 5) begin
            n_bad++;
            $display("FAIL t3 run_len: got %0d busy cycles, want %0d", b, busy_t1 + 5);
        end
    endtask

    task automatic test_odd_cols;
        int b;
        run_cfg("t4_oddcols", 1, 1, 4, 0, 1, 0, 63, 1, 0, 0, b);
    endtask

    task automatic test_err;
        int b;
        run_cfg("t5_err", 1, 2, 7, 0, 9, 0, 63, 0, 0, 0, b);
        run_cfg("t5_sticky", 0, 1, 3, 0, 1, 0, 63, 0, 0, 1, b);
    endtask

    task automatic test_stride_zero;
        int b;
        run_cfg("stride0", 1, 1, 3, 1, 0, 1, 63, 0, 0, 0, b);
    endtask

    task automatic test_wrap_suppress;
        int b;
        run_cfg("wrap", 1, 0, 15, 7, 2, 1, 255, 0, 0, 0, b);
        run_cfg("suppress", 1, 1, 7, 2, 1, 0, 4, 0, 0, 0, b);
    endtask

    task automatic test_soft_reset;
        int b;
        do_reset();
        @(posedge clk); #1;
        kern_cols_i = 3'd1;
        cols_i = 8'd7;
        kerns_i = 3'd2;
        stride_i = 8'd1;
        kern_addr_mode_i = 1'b0;
        result_cols_i = 8'd63;
        en_max_pool_i = 1'b1;
        start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        soft_rst_i = 1'b1;
        start_i = 1'b0;
        obs_rd.delete();
        obs_wr.delete();
        obs_cap = 0;
        @(posedge clk); #1;
        soft_rst_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL t6 soft_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_rd.size() != 0 || obs_wr.size() != 0 || obs_cap != 0) begin
            n_bad++;
            $display("FAIL t6 quiet: got rd=%0d wr=%0d cap=%0d, want 0 0 0",
                     obs_rd.size(), obs_wr.size(), obs_cap);
        end
        run_cfg("t6_rerun", 0, 1, 7, 2, 1, 0, 63, 1, 0, 0, b);
    endtask

    task automatic test_back_to_back;
        int b;
        run_cfg("b2b_a", 1, 2, 5, 1, 2, 1, 63, 1, 0, 0, b);
        run_cfg("b2b_b", 0, 0, 6, 3, 1, 0, 63, 1, 0, 0, b);
    endtask

    task automatic test_random;
        int b;
        for (int it = 0; it < 8; it++) begin
            run_cfg("rand", 1,
                    $urandom_range(0, 4), $urandom_range(0, 9),
                    $urandom_range(0, 3), $urandom_range(0, 9),
                    $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 1), 2, 0, b);
        end
    endtask

    initial begin
        test_reset();
        test_pool();
        test_nopool_mode1();
        test_stall();
        test_odd_cols();
        test_err();
        test_stride_zero();
        test_wrap_suppress();
        test_soft_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
